// File: rtl/frac_lut_dbuf_cfg.sv
// frac_lut_dbuf_cfg
//   K-input fracturable LUT tile with a double-buffered configuration.
//   Configuration bits are shifted MSB first through a counted scan chain into
//   a shadow register. A commit copies the shadow into the active register in
//   one cycle. The LUT only ever evaluates the active copy, so the old function
//   keeps running while a new one is shifted in.
//
//   Configuration word layout (CFG_BITS = TT_BITS + 2):
//     [TT_BITS-1:0]  truth table
//     [TT_BITS]      frac_mode  (out0 uses the lower half-table)
//     [TT_BITS+1]    out_reg_en (outputs registered, one cycle of latency)
//
// Ports
//   prog_clk        sole clock, rising edge
//   pReset          synchronous active-low reset
//   ccff_head       serial configuration data in
//   ccff_en         shift enable
//   cfg_commit      copy shadow to active (accepted only when the chain is full)
//   frac_logic_in   LUT inputs, bit 0 is the LSB of the table index
//   frac_logic_out  {out1, out0}
//   ccff_tail       serial data out, MSB of the shadow register
//   cfg_done        one-cycle pulse after an accepted commit
//   cfg_err         sticky protocol error, cleared only by reset

module frac_lut_dbuf_cfg #(
    parameter int unsigned K        = 6,
    parameter int unsigned TT_BITS  = 2 ** K,
    parameter int unsigned CFG_BITS = TT_BITS + 2,
    parameter int unsigned CNT_W    = $clog2(CFG_BITS + 1)
) (
    input  logic         prog_clk,
    input  logic         pReset,
    input  logic         ccff_head,
    input  logic         ccff_en,
    input  logic         cfg_commit,
    input  logic [K-1:0] frac_logic_in,
    output logic [1:0]   frac_logic_out,
    output logic         ccff_tail,
    output logic         cfg_done,
    output logic         cfg_err
);

    localparam int unsigned FracBit   = TT_BITS;
    localparam int unsigned OutRegBit = TT_BITS + 1;

    localparam logic [CNT_W-1:0] CntFull = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(CFG_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFull
    } state_e;

    state_e                state_q, state_d;
    logic [CFG_BITS-1:0]   shadow_q, shadow_d;
    logic [CFG_BITS-1:0]   active_q, active_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [1:0]            out_q, out_d;

    logic                  commit_ok;
    logic                  shift_en;

    // A commit is only honoured with a full chain, and it blocks any shift in
    // the same cycle so the committed word is exactly what was shifted in.
    assign commit_ok = (state_q == StFull) && cfg_commit;
    assign shift_en  = ccff_en && !commit_ok;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            active_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            out_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            count_q  <= count_d;
            done_q   <= done_d;
            err_q    <= err_d;
            out_q    <= out_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (shift_en) begin
                    state_d = (count_q == CntLast) ? StFull : StShift;
                end
            end
            StShift: begin
                if (shift_en && (count_q == CntLast)) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (commit_ok) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / status updates driven by the FSM decode
    // ------------------------------------------------------------------
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        count_d  = count_q;
        err_d    = err_q;
        done_d   = commit_ok;

        if (commit_ok) begin
            // Shadow is kept so it can still be read back on ccff_tail.
            active_d = shadow_q;
            count_d  = '0;
        end else if (shift_en) begin
            shadow_d = {shadow_q[CFG_BITS-2:0], ccff_head};
            if (count_q != CntFull) begin
                count_d = count_q + CNT_W'(1);
            end
        end

        // Premature commit.
        if (cfg_commit && (state_q != StFull)) begin
            err_d = 1'b1;
        end
        // Over-shift: data still moves, but the word no longer lines up.
        if (shift_en && (state_q == StFull)) begin
            err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // LUT evaluation from the active configuration only
    // ------------------------------------------------------------------
    logic [TT_BITS-1:0] tt;
    logic               frac_mode;
    logic               out_reg_en;
    logic [K-1:0]       idx_lo;
    logic [K-1:0]       idx_hi;
    logic               lut_full;
    logic               lut_lo;
    logic               lut_hi;
    logic [1:0]         pre_out;

    assign tt         = active_q[TT_BITS-1:0];
    assign frac_mode  = active_q[FracBit];
    assign out_reg_en = active_q[OutRegBit];

    // Fractured halves ignore the top input and pick the lower/upper table.
    assign idx_lo = {1'b0, frac_logic_in[K-2:0]};
    assign idx_hi = {1'b1, frac_logic_in[K-2:0]};

    always_comb begin
        lut_full = tt[frac_logic_in];
        lut_lo   = tt[idx_lo];
        lut_hi   = tt[idx_hi];
        pre_out  = {lut_hi, (frac_mode ? lut_lo : lut_full)};
        // Loaded every cycle so a mode switch on commit shows at most
        // one-cycle-old data.
        out_d    = pre_out;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign frac_logic_out = out_reg_en ? out_q : pre_out;
    assign ccff_tail      = shadow_q[CFG_BITS-1];
    assign cfg_done       = done_q;
    assign cfg_err        = err_q;

endmodule

// File: tb/tb_frac_lut_dbuf_cfg.sv
// Self-checking bench for frac_lut_dbuf_cfg at K=4 (chain length 18).
// Expected LUT outputs are pushed to a scoreboard queue when the inputs are
// driven and popped when the DUT output is due.

module tb_frac_lut_dbuf_cfg;

    localparam int unsigned K = 4;
    localparam int unsigned L = 18;

    logic         prog_clk;
    logic         pReset;
    logic         ccff_head;
    logic         ccff_en;
    logic         cfg_commit;
    logic [K-1:0] frac_logic_in;
    logic [1:0]   frac_logic_out;
    logic         ccff_tail;
    logic         cfg_done;
    logic         cfg_err;

    int unsigned  n_checks;
    int unsigned  n_errors;
    logic [1:0]   sb_q[$];

    frac_lut_dbuf_cfg #(
        .K(K)
    ) u_dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .ccff_head     (ccff_head),
        .ccff_en       (ccff_en),
        .cfg_commit    (cfg_commit),
        .frac_logic_in (frac_logic_in),
        .frac_logic_out(frac_logic_out),
        .ccff_tail     (ccff_tail),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference LUT: word is {out_reg_en, frac_mode, tt[15:0]}.
    function automatic logic [1:0] lut_model(input logic [17:0] w, input logic [3:0] v);
        logic [15:0] tbl;
        int          lo_i;
        int          hi_i;
        logic        o0;
        logic        o1;
        tbl  = w[15:0];
        lo_i = int'(v) % 8;
        hi_i = lo_i + 8;
        o0   = w[16] ? tbl[lo_i] : tbl[int'(v)];
        o1   = tbl[hi_i];
        return {o1, o0};
    endfunction

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        pReset = 1'b0;
        repeat (cycles) tick();
        pReset = 1'b1;
    endtask

    task automatic shift_word(input logic [17:0] w);
        for (int i = L - 1; i >= 0; i--) begin
            ccff_head = w[i];
            ccff_en   = 1'b1;
            tick();
        end
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
    endtask

    task automatic shift_const(input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            ccff_head = b;
            ccff_en   = 1'b1;
            tick();
        end
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    // Combinational mode: result due in the same cycle as the input.
    task automatic chk_comb(input string tag, input logic [3:0] v, input logic [17:0] w);
        logic [1:0] exp_v;
        frac_logic_in = v;
        sb_q.push_back(lut_model(w, v));
        #1;
        exp_v = sb_q.pop_front();
        check_eq(tag, {30'd0, frac_logic_out}, {30'd0, exp_v});
        tick();
    endtask

    // Registered mode: output holds the previous value until the next edge.
    task automatic chk_reg(input string tag, input logic [3:0] v, input logic [17:0] w,
                           inout logic [1:0] prev);
        logic [1:0] exp_v;
        frac_logic_in = v;
        sb_q.push_back(lut_model(w, v));
        #1;
        check_eq({tag, "_hold"}, {30'd0, frac_logic_out}, {30'd0, prev});
        tick();
        exp_v = sb_q.pop_front();
        check_eq(tag, {30'd0, frac_logic_out}, {30'd0, exp_v});
        prev = exp_v;
    endtask

    localparam logic [17:0] WAnd4 = 18'h08000;
    localparam logic [17:0] WFrac = 18'h180FE;
    localparam logic [17:0] WReg  = 18'h380FE;

    initial begin
        logic [1:0] prev;
        logic       bits [0:18];
        logic [17:0] wtmp;

        n_checks      = 0;
        n_errors      = 0;
        pReset        = 1'b0;
        ccff_head     = 1'b0;
        ccff_en       = 1'b0;
        cfg_commit    = 1'b0;
        frac_logic_in = '0;

        // ---------------- Reset with random inputs ----------------
        for (int i = 0; i < 2; i++) begin
            ccff_head     = 1'($urandom);
            ccff_en       = 1'($urandom);
            cfg_commit    = 1'($urandom);
            frac_logic_in = 4'($urandom);
            tick();
        end
        check_eq("rst_out", {30'd0, frac_logic_out}, 32'd0);
        check_eq("rst_tail", {31'd0, ccff_tail}, 32'd0);
        check_eq("rst_done", {31'd0, cfg_done}, 32'd0);
        check_eq("rst_err", {31'd0, cfg_err}, 32'd0);
        pReset        = 1'b1;
        ccff_head     = 1'b0;
        ccff_en       = 1'b0;
        cfg_commit    = 1'b0;
        frac_logic_in = '0;
        tick();

        // ---------------- AND4 ----------------
        shift_word(WAnd4);
        check_eq("and4_pre_done", {31'd0, cfg_done}, 32'd0);
        do_commit();
        check_eq("and4_done", {31'd0, cfg_done}, 32'd1);
        check_eq("and4_err", {31'd0, cfg_err}, 32'd0);
        chk_comb("and4_F", 4'hF, WAnd4);
        check_eq("and4_done_low", {31'd0, cfg_done}, 32'd0);
        check_eq("and4_F_const", {30'd0, lut_model(WAnd4, 4'hF)}, 32'd3);
        chk_comb("and4_E", 4'hE, WAnd4);
        for (int i = 0; i < 6; i++) chk_comb("and4_rand", 4'($urandom), WAnd4);

        // Reset glitch between edges must not disturb anything.
        frac_logic_in = 4'hF;
        pReset = 1'b0;
        #2;
        pReset = 1'b1;
        tick();
        check_eq("glitch_out", {30'd0, frac_logic_out}, 32'd3);
        check_eq("glitch_err", {31'd0, cfg_err}, 32'd0);

        // ---------------- Fractured ----------------
        shift_word(WFrac);
        do_commit();
        check_eq("frac_done", {31'd0, cfg_done}, 32'd1);
        chk_comb("frac_1", 4'b0001, WFrac);
        chk_comb("frac_7", 4'b0111, WFrac);
        chk_comb("frac_0", 4'b0000, WFrac);
        for (int i = 0; i < 6; i++) chk_comb("frac_rand", 4'($urandom), WFrac);

        // ---------------- Registered + double buffer ----------------
        shift_word(WReg);
        frac_logic_in = 4'h0;
        do_commit();
        check_eq("reg_done", {31'd0, cfg_done}, 32'd1);
        tick();
        prev = lut_model(WReg, 4'h0);
        for (int i = 0; i < 8; i++) chk_reg("reg_step", 4'(i), WReg, prev);
        shift_word(18'h00000);
        check_eq("dbuf_err", {31'd0, cfg_err}, 32'd0);
        check_eq("dbuf_done", {31'd0, cfg_done}, 32'd0);
        for (int i = 0; i < 16; i++) chk_reg("dbuf_keep", 4'(i), WReg, prev);

        // ---------------- Premature commit ----------------
        do_reset(2);
        shift_word(WAnd4);
        do_commit();
        check_eq("early_setup_done", {31'd0, cfg_done}, 32'd1);
        shift_const(10, 1'b0);
        do_commit();
        check_eq("early_done", {31'd0, cfg_done}, 32'd0);
        check_eq("early_err", {31'd0, cfg_err}, 32'd1);
        chk_comb("early_keep_F", 4'hF, WAnd4);
        chk_comb("early_keep_7", 4'h7, WAnd4);

        // ---------------- Over-shift + commit with shift ----------------
        do_reset(1);
        check_eq("reset_clears_err", {31'd0, cfg_err}, 32'd0);
        wtmp    = WFrac;
        bits[0] = 1'b1;
        for (int i = 0; i < 18; i++) bits[i+1] = wtmp[17-i];
        for (int j = 1; j <= 19; j++) begin
            ccff_head = bits[j-1];
            ccff_en   = 1'b1;
            tick();
            check_eq("over_tail", {31'd0, ccff_tail}, {31'd0, (j >= 18) ? bits[j-18] : 1'b0});
            if (j == 18) check_eq("full_no_err", {31'd0, cfg_err}, 32'd0);
            if (j == 19) check_eq("over_err", {31'd0, cfg_err}, 32'd1);
        end
        ccff_head  = 1'b1;
        ccff_en    = 1'b1;
        cfg_commit = 1'b1;
        tick();
        ccff_en    = 1'b0;
        cfg_commit = 1'b0;
        check_eq("cws_done", {31'd0, cfg_done}, 32'd1);
        check_eq("cws_noshift", {31'd0, ccff_tail}, {31'd0, bits[1]});
        check_eq("cws_err_sticky", {31'd0, cfg_err}, 32'd1);
        chk_comb("cws_frac_1", 4'b0001, WFrac);
        chk_comb("cws_frac_7", 4'b0111, WFrac);

        // ---------------- Reset mid-shift ----------------
        do_reset(2);
        shift_const(7, 1'b1);
        do_reset(1);
        shift_word(WAnd4);
        do_commit();
        check_eq("mid_done", {31'd0, cfg_done}, 32'd1);
        check_eq("mid_err", {31'd0, cfg_err}, 32'd0);
        chk_comb("mid_F", 4'hF, WAnd4);
        chk_comb("mid_E", 4'hE, WAnd4);
        check_eq("mid_err_end", {31'd0, cfg_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
